// File: rtl/cci_mpf_prim_fifo_bram_prefetch.sv
// cci_mpf_prim_fifo_bram_prefetch
//   BRAM-backed FIFO with a small register prefetch buffer in front of the
//   RAM read port. `first` comes straight from a register. Steady-state
//   throughput is one entry per cycle for any RAM read latency.
//
//   Optional build macro CCI_MPF_PRIM_FIFO_BRAM_CHECK_EN adds simulation-only
//   protocol checks: enqueue when full, dequeue when empty, and prefetch
//   credit overflow. Synthesized logic is identical with or without it.
//
//   cci_mpf_prim_ram_simple, the simple dual-port RAM primitive, lives in
//   this file too, so the block is self-contained.

// Simple dual-port RAM: one write port and one read port.
// Read latency is 1 + N_OUTPUT_REG_STAGES cycles.
module cci_mpf_prim_ram_simple
  #(
    parameter int N_ENTRIES = 32,
    parameter int N_DATA_BITS = 64,
    parameter int N_OUTPUT_REG_STAGES = 0
    )
   (
    input  logic clk,
    input  logic wen,
    input  logic [$clog2(N_ENTRIES)-1:0] waddr,
    input  logic [N_DATA_BITS-1:0] wdata,
    input  logic [$clog2(N_ENTRIES)-1:0] raddr,
    output logic [N_DATA_BITS-1:0] rdata
    );

    logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
    logic [N_DATA_BITS-1:0] pipe [N_OUTPUT_REG_STAGES+1];

    // Write port, registered read, then optional output register stages.
    always_ff @(posedge clk) begin
        if (wen) mem[waddr] <= wdata;
        pipe[0] <= mem[raddr];
        for (int i = 1; i <= N_OUTPUT_REG_STAGES; i++) pipe[i] <= pipe[i-1];
    end

    assign rdata = pipe[N_OUTPUT_REG_STAGES];

endmodule


module cci_mpf_prim_fifo_bram_prefetch
  #(
    parameter int N_ENTRIES = 32,
    parameter int N_DATA_BITS = 64,
    parameter int N_OUTPUT_REG_STAGES = 0,
    parameter int N_MIN_FREE_ENTRIES = 2
    )
   (
    input  logic clk,
    input  logic reset,

    input  logic [N_DATA_BITS-1:0] enq_data,
    input  logic enq_en,
    output logic notFull,
    output logic almostFull,

    output logic [N_DATA_BITS-1:0] first,
    input  logic deq_en,
    output logic notEmpty
    );

    localparam int L = 1 + N_OUTPUT_REG_STAGES;
    localparam int PF_DEPTH = L + 1;
    localparam int AW = $clog2(N_ENTRIES);
    localparam int PW = $clog2(PF_DEPTH);
    // Wide enough for pf_count + inflight without overflow.
    localparam int CW = $clog2(PF_DEPTH + 1) + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   used_t;
    typedef logic [CW-1:0] cnt_t;

    ptr_t  wr_ptr, rd_ptr;
    used_t ram_used, ram_used_next;
    logic  [L-1:0] vld_pipe, vld_pipe_next;
    cnt_t  pf_count, pf_count_next;
    cnt_t  inflight, credit;
    logic  [PW-1:0] pf_widx;
    logic  [N_DATA_BITS-1:0] pf_data [PF_DEPTH];
    logic  [N_DATA_BITS-1:0] rdata;
    logic  issue, push, pop;
    logic  not_full_q, almost_full_q;

    cci_mpf_prim_ram_simple
      #(
        .N_ENTRIES(N_ENTRIES),
        .N_DATA_BITS(N_DATA_BITS),
        .N_OUTPUT_REG_STAGES(N_OUTPUT_REG_STAGES)
        )
      ram
       (
        .clk(clk),
        .wen(enq_en),
        .waddr(wr_ptr),
        .wdata(enq_data),
        .raddr(rd_ptr),
        .rdata(rdata)
        );

    // Issue/capture decisions and next-state counters.
    //   ram_used doubles as the "ready to issue" count. A write in the current
    //   cycle only shows up in it after the edge, so a slot is never read in
    //   the cycle it is written.
    //   The prefetch credit counts buffered entries plus reads in flight. A
    //   dequeue this cycle frees its slot for the issue decision. This is what
    //   lets PF_DEPTH = L+1 cover the whole issue-to-pop loop without bubbles.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < L; i++) inflight = inflight + cnt_t'(vld_pipe[i]);

        pop  = deq_en && (pf_count != '0);
        push = vld_pipe[L-1];

        credit = pf_count + inflight - cnt_t'(pop);
        issue  = (ram_used != '0) && (credit < cnt_t'(PF_DEPTH));

        vld_pipe_next    = vld_pipe << 1;
        vld_pipe_next[0] = issue;

        ram_used_next = ram_used + used_t'(enq_en) - used_t'(issue);
        pf_count_next = pf_count + cnt_t'(push) - cnt_t'(pop);

        // The new entry lands just behind whatever survives this cycle's pop.
        pf_widx = PW'(pf_count - cnt_t'(pop));
    end

    // Pointers, occupancy, the in-flight valid pipe and the registered flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            ram_used      <= '0;
            vld_pipe      <= '0;
            pf_count      <= '0;
            not_full_q    <= 1'b1;
            almost_full_q <= 1'b0;
        end else begin
            if (enq_en) wr_ptr <= wr_ptr + ptr_t'(1);
            if (issue)  rd_ptr <= rd_ptr + ptr_t'(1);
            ram_used      <= ram_used_next;
            vld_pipe      <= vld_pipe_next;
            pf_count      <= pf_count_next;
            not_full_q    <= (ram_used_next != used_t'(N_ENTRIES));
            almost_full_q <= ((used_t'(N_ENTRIES) - ram_used_next) <=
                              used_t'(N_MIN_FREE_ENTRIES));
        end
    end

    // Prefetch buffer data: slot 0 is the head. A pop shifts the entries
    // down, and a capture writes the returning RAM data behind them.
    always_ff @(posedge clk) begin
        if (pop) begin
            for (int i = 0; i < PF_DEPTH - 1; i++) pf_data[i] <= pf_data[i+1];
        end
        if (push) pf_data[pf_widx] <= rdata;
    end

    assign first      = pf_data[0];
    assign notEmpty   = (pf_count != '0);
    assign notFull    = not_full_q;
    assign almostFull = almost_full_q;

`ifdef CCI_MPF_PRIM_FIFO_BRAM_CHECK_EN
    // Protocol and internal credit checks, active outside reset.
    always @(posedge clk) begin
        if (!reset) begin
            if (enq_en && !notFull) $fatal(1, "enq to full FIFO");
            if (deq_en && !notEmpty) $fatal(1, "deq from empty FIFO");
            if ((pf_count + inflight) > cnt_t'(PF_DEPTH))
                $fatal(1, "prefetch credit overflow");
        end
    end
`else
`endif

endmodule

// File: tb/tb_cci_mpf_prim_fifo_bram_prefetch.sv
// Self-checking bench for cci_mpf_prim_fifo_bram_prefetch.
// There are two instances with N_ENTRIES=8: one with read latency 1 and one
// with read latency 3. `sel` routes stimulus to one instance at a time.
// A queue scoreboard predicts the data order.
module tb_cci_mpf_prim_fifo_bram_prefetch;
    localparam int N = 8;
    localparam int W = 64;
    localparam int MINFREE = 2;

    logic clk = 1'b0;
    logic reset;
    logic [W-1:0] enq_data;
    logic enq_en, deq_en, sel;

    logic enq0, deq0, enq1, deq1;
    logic nf0, af0, ne0, nf1, af1, ne1;
    logic [W-1:0] f0, f1;
    logic nf, af, ne;
    logic [W-1:0] fst;

    assign enq0 = enq_en & ~sel;
    assign deq0 = deq_en & ~sel;
    assign enq1 = enq_en & sel;
    assign deq1 = deq_en & sel;
    assign nf  = sel ? nf1 : nf0;
    assign af  = sel ? af1 : af0;
    assign ne  = sel ? ne1 : ne0;
    assign fst = sel ? f1  : f0;

    cci_mpf_prim_fifo_bram_prefetch
      #(.N_ENTRIES(N), .N_DATA_BITS(W), .N_OUTPUT_REG_STAGES(0), .N_MIN_FREE_ENTRIES(MINFREE))
      dut0 (.clk(clk), .reset(reset), .enq_data(enq_data), .enq_en(enq0), .notFull(nf0),
            .almostFull(af0), .first(f0), .deq_en(deq0), .notEmpty(ne0));

    cci_mpf_prim_fifo_bram_prefetch
      #(.N_ENTRIES(N), .N_DATA_BITS(W), .N_OUTPUT_REG_STAGES(2), .N_MIN_FREE_ENTRIES(MINFREE))
      dut1 (.clk(clk), .reset(reset), .enq_data(enq_data), .enq_en(enq1), .notFull(nf1),
            .almostFull(af1), .first(f1), .deq_en(deq1), .notEmpty(ne1));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] q[$];

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle. Inputs are set at a negedge, and the head is checked
    // against the scoreboard before the edge that pops it.
    task automatic cyc(input bit e, input logic [W-1:0] d, input bit dq);
        enq_en = e;
        enq_data = d;
        deq_en = dq;
        if (e) q.push_back(d);
        if (dq && q.size() > 0) chk("first", fst, q.pop_front());
        @(negedge clk);
        enq_en = 1'b0;
        deq_en = 1'b0;
    endtask

    task automatic reset_pulse();
        enq_en = 1'b0;
        deq_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (ne && n < 64) begin
            cyc(0, '0, 1);
            n++;
        end
        chk({tag, "_left"}, W'(q.size()), '0);
        chk({tag, "_empty"}, W'(ne), '0);
    endtask

    initial begin
        int lat, pf, cnt, af_cnt, sent, bound;
        logic [W-1:0] v;
        bit e, dq, exp_af;

        sel = 1'b0;
        enq_en = 1'b0;
        deq_en = 1'b0;
        enq_data = '0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            lat = s ? 3 : 1;
            pf = lat + 1;

            // Idle after reset: the FIFO is empty, not full and not almost full.
            for (int i = 0; i < 10; i++) begin
                chk("rst_nf", W'(nf), 1);
                chk("rst_af", W'(af), 0);
                chk("rst_ne", W'(ne), 0);
                cyc(0, '0, 0);
            end

            // Single entry: notEmpty rises exactly 2+L cycles after the enqueue.
            cyc(1, 'hA5, 0);
            for (int i = 0; i < lat + 1; i++) begin
                chk("lat_early", W'(ne), 0);
                cyc(0, '0, 0);
            end
            chk("lat_ne", W'(ne), 1);
            chk("lat_first", fst, 'hA5);
            cyc(0, '0, 1);
            chk("lat_deq_ne", W'(ne), 0);

            // Fill: RAM capacity plus the prefetch buffer depth.
            cnt = 0;
            af_cnt = -1;
            while (nf && cnt < 32) begin
                cyc(1, W'(cnt), 0);
                cnt++;
                if (af && af_cnt < 0) af_cnt = cnt;
            end
            chk("fill_count", W'(cnt), W'(N + pf));
            chk("fill_af_at", W'(af_cnt), W'(N - MINFREE + pf));
            chk("fill_nf", W'(nf), 0);
            chk("fill_af", W'(af), 1);
            for (int i = 0; i < 2 * lat + 2; i++) cyc(0, '0, 0);
            drain("fill_drain");
            chk("fill_nf_after", W'(nf), 1);
            chk("fill_af_after", W'(af), 0);

            // Streaming: prime 8 entries and let the buffer settle, then
            // enqueue and dequeue every cycle. The RAM backlog stays at
            // 8 - PF_DEPTH for the whole run.
            for (int i = 0; i < 8; i++) cyc(1, W'(1000 + i), 0);
            for (int i = 0; i < 2 * lat + 2; i++) cyc(0, '0, 0);
            exp_af = ((N - (8 - pf)) <= MINFREE);
            for (int i = 0; i < 100; i++) begin
                chk("strm_ne", W'(ne), 1);
                chk("strm_nf", W'(nf), 1);
                chk("strm_af", W'(af), W'(exp_af));
                cyc(1, W'(2000 + i), 1);
            end
            drain("strm_drain");

            // Wrap-around: 3*N entries with random gaps on both sides.
            sent = 0;
            bound = 0;
            while ((sent < 3 * N || q.size() > 0) && bound < 3000) begin
                if (q.size() == 0) chk("wrap_ne_model", W'(ne), 0);
                e  = nf && (sent < 3 * N) && ($urandom_range(2) != 0);
                dq = ne && ($urandom_range(1) != 0);
                v  = {$urandom, $urandom};
                if (e) sent++;
                cyc(e, v, dq);
                bound++;
            end
            chk("wrap_done", W'(q.size()), '0);
            chk("wrap_sent", W'(sent), W'(3 * N));
        end

        // Reset while two reads are in flight (latency-3 instance).
        sel = 1'b1;
        lat = 3;
        cyc(1, 'h11, 0);
        cyc(1, 'h22, 0);
        cyc(0, '0, 0);
        reset_pulse();
        chk("mid_rst_ne", W'(ne), 0);
        chk("mid_rst_nf", W'(nf), 1);
        for (int i = 0; i < lat + 2; i++) begin
            chk("mid_rst_stale", W'(ne), 0);
            cyc(0, '0, 0);
        end
        cyc(1, 'h55, 0);
        cnt = 0;
        while (!ne && cnt < 10) begin
            cyc(0, '0, 0);
            cnt++;
        end
        chk("mid_rst_lat", W'(cnt), W'(lat + 1));
        chk("mid_rst_first", fst, 'h55);
        cyc(0, '0, 1);
        chk("mid_rst_ne_end", W'(ne), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cci_mpf_prim_fifo_bram_prefetch.md
Name: cci_mpf_prim_fifo_bram_prefetch

Overview:
- FIFO built on the team's simple dual-port RAM primitive (cci_mpf_prim_ram_simple), instantiated internally.
- Generates RAM write and read addresses and consumes the RAM's pipelined read data into a small register prefetch buffer, so `first` is registered and steady-state throughput is 1 entry/cycle despite RAM read latency.
- Used wherever a deep, BRAM-backed request/response queue is needed.

Parameters:
- N_ENTRIES, 32: RAM capacity; power of 2, >= 4.
- N_DATA_BITS, 64: entry width.
- N_OUTPUT_REG_STAGES, 0: passed to the RAM. Read latency L = 1 + N_OUTPUT_REG_STAGES.
- N_MIN_FREE_ENTRIES, 2: almostFull threshold, measured in free RAM slots.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enq_data  in  N_DATA_BITS  data to enqueue
- enq_en  in  1  enqueue this cycle
- notFull  out  1  RAM has at least one free slot
- almostFull  out  1  free RAM slots <= N_MIN_FREE_ENTRIES
- first  out  N_DATA_BITS  head entry; valid when notEmpty
- deq_en  in  1  dequeue head this cycle
- notEmpty  out  1  prefetch buffer holds at least one entry

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- During and after reset:
  - wr_ptr, rd_ptr and ram_used are 0.
  - In-flight valid shift register and prefetch buffer are cleared.
  - Outputs: notEmpty=0, notFull=1, almostFull=0 (N_MIN_FREE_ENTRIES < N_ENTRIES). first is don't-care.
  - Reset during in-flight reads discards the returning RAM data; it is never captured.
- Enqueue: when enq_en=1, RAM is written at wr_ptr and wr_ptr increments with wrap modulo N_ENTRIES. Caller must only enqueue when notFull=1.
- Read issue:
  - ram_ready counts entries written in earlier cycles and not yet issued. An entry written in cycle t becomes issuable in cycle t+1, which avoids mixed-port old-data returns.
  - A read issues in a cycle iff ram_ready > 0 and (pf_count + inflight) < PF_DEPTH, where PF_DEPTH = L+1.
  - On issue: raddr=rd_ptr, rd_ptr increments with wrap, and a 1 enters an L-deep valid shift register.
- Capture: when the shift-register tail is 1, RAM rdata is pushed into the prefetch buffer at the end of that cycle.
- Prefetch buffer: register FIFO of PF_DEPTH entries.
  - first = head entry, driven from a register.
  - deq_en pops the head.
  - Push and pop in the same cycle are both honoured.
- Occupancy: ram_used counts slots written and not yet read-issued.
  - +1 on enq, -1 on issue; both in the same cycle leaves it unchanged.
  - notFull = (ram_used != N_ENTRIES).
  - almostFull = (N_ENTRIES - ram_used) <= N_MIN_FREE_ENTRIES.
  - Both are registered: computed from next-state values.
- Latency: with an empty FIFO, enq in cycle t gives notEmpty=1 first in cycle t+2+L.
- Throughput: with the buffer primed, continuous enq/deq sustains 1 entry/cycle, because PF_DEPTH covers the loop latency.
- Wrap-around: pointers are $clog2(N_ENTRIES) bits and wrap naturally. ram_used is $clog2(N_ENTRIES)+1 bits so full and empty are distinguishable.
- Illegal operations (enq when notFull=0, deq when notEmpty=0): state is undefined unless checks are compiled in.
- Ordering: strict FIFO; data is never reordered or duplicated.

Optional Feature:
- Macro: CCI_MPF_PRIM_FIFO_BRAM_CHECK_EN.
- Defined: adds simulation-only checks, evaluated on posedge clk when reset=0.
  - enq_en && !notFull → $fatal with message "enq to full FIFO".
  - deq_en && !notEmpty → $fatal with message "deq from empty FIFO".
  - (pf_count + inflight) > PF_DEPTH → $fatal.
- Not defined: no checks are generated and the RTL is otherwise identical.
- Synthesis result is the same either way.

Test Plan:
- Reset, then idle with N_ENTRIES=8 and L=1 → notFull=1, almostFull=0, notEmpty=0 for 10 cycles.
- Single enq of 0xA5 at cycle 5 → notEmpty rises at cycle 8 with first=0xA5. deq at cycle 8 → notEmpty=0 at cycle 9.
- Fill: 8 back-to-back enqs of 0..7 with no deq.
  - almostFull=1 once free slots <= 2.
  - notFull=0 only after the prefetch buffer (2 entries) is full and ram_used reaches 8; total stored is 10 with enqs continued while notFull=1.
  - Drain returns 0..9 in order.
- Streaming: enq and deq every cycle for 100 cycles of an incrementing pattern, after a 4-cycle prime → no bubble in notEmpty, values in order, ram_used stable. Repeat with N_OUTPUT_REG_STAGES=2.
- Wrap-around: 3 × N_ENTRIES entries with random enq/deq gaps → output sequence matches a scoreboard and pointer wrap causes no loss.
- Reset mid-stream: assert reset for 1 cycle while 2 reads are in flight → notEmpty=0 the next cycle, and the first post-reset enq of 0x55 is the first value seen on first.
